// File: rtl/db15_pkg.sv
// db15_pkg: shared constants, FSM state type and bit-to-joystick mapping for
// the DB15 two-player adapter reader.
//   NBITS / BITS_PER_PLAYER : serial frame geometry (2 x 12 active-low bits)
//   BTN_*                   : position of each button inside a 12-bit player slice
//   state_e                 : reader FSM states
//   to_joy()                : 12 raw active-low bits -> 16-bit active-high word
package db15_pkg;

  localparam int unsigned NBITS           = 24;
  localparam int unsigned BITS_PER_PLAYER = 12;
  localparam int unsigned BIT_W           = 5;   // indexes 0..NBITS-1
  localparam int unsigned CNT_W           = 8;   // tick counter, holds up to 255
  localparam int unsigned JOY_W           = 16;
  localparam int unsigned LOAD_TICKS      = 2;

  // Button positions within one player's slice; R is shifted in first.
  localparam int unsigned BTN_R     = 0;
  localparam int unsigned BTN_L     = 1;
  localparam int unsigned BTN_DOWN  = 2;
  localparam int unsigned BTN_UP    = 3;
  localparam int unsigned BTN_A     = 4;
  localparam int unsigned BTN_B     = 5;
  localparam int unsigned BTN_C     = 6;
  localparam int unsigned BTN_D     = 7;
  localparam int unsigned BTN_E     = 8;
  localparam int unsigned BTN_F     = 9;
  localparam int unsigned BTN_S     = 10;
  localparam int unsigned BTN_LB    = 11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_LATCH,
    ST_GAP
  } state_e;

  // Active-low raw slice to the "LS FEDCBAUDLR" active-high joystick word.
  function automatic logic [JOY_W-1:0] to_joy(input logic [BITS_PER_PLAYER-1:0] raw);
    return {4'b0000, ~raw};
  endfunction

endpackage

// File: rtl/db15_tick_gen.sv
// db15_tick_gen: free-running divider producing one-clk tick pulses every
// CLK_DIV clocks; a tick is one half-period of the adapter shift clock.
//   clk      : system clock
//   reset    : asynchronous, active-high
//   enable_i : divider runs while high, held cleared while low
//   tick_o   : registered, high for one clk while the divider sits at CLK_DIV-1
module db15_tick_gen #(
  parameter int unsigned CLK_DIV = 24
) (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  output logic tick_o
);

  localparam int unsigned DIV_W = 8;

  logic [DIV_W-1:0] div_q;
  logic             tick_q;

  // tick_q is set one count early so it is high exactly while div_q == CLK_DIV-1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else if (!enable_i) begin
      div_q  <= '0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= (div_q == DIV_W'(CLK_DIV - 1)) ? '0 : div_q + DIV_W'(1);
      tick_q <= (div_q == DIV_W'(CLK_DIV - 2));
    end
  end

  assign tick_o = tick_q;

endmodule

// File: rtl/db15_joy_reader.sv
// db15_joy_reader: drives the DB15 adapter's load/clock lines, shifts in 24
// active-low button bits per frame and publishes two joystick words.
//   clk, reset      : system clock, asynchronous active-high reset
//   enable          : reader active; low aborts the frame and clears outputs
//   joy_data        : serial adapter data, active low, asynchronous
//   joy_clk         : adapter shift clock, idles high
//   joy_load        : adapter parallel load, active low
//   joystick1/2     : {4'b0, L, S, F, E, D, C, B, A, U, D, L, R}, active high
//   frame_done      : one-clk pulse when the joystick outputs are refreshed
//   present         : adapter detected (frame not all-low)
// Build option: define DB15_DEBOUNCE_EN to publish a frame only when it
// matches the previous frame.
module db15_joy_reader
  import db15_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 24,
  parameter int unsigned GAP_TICKS = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             joy_data,
  output logic             joy_clk,
  output logic             joy_load,
  output logic [JOY_W-1:0] joystick1,
  output logic [JOY_W-1:0] joystick2,
  output logic             frame_done,
  output logic             present
);

  logic tick;

  db15_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick_gen (
    .clk      (clk),
    .reset    (reset),
    .enable_i (enable),
    .tick_o   (tick)
  );

  state_e             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [BIT_W-1:0]   bit_q;
  logic               phase_q;     // 0: joy_clk low half, 1: high half
  logic [NBITS-1:0]   raw_q;
  logic [1:0]         sync_q;
  logic               joy_clk_q;
  logic               joy_load_q;
  logic [JOY_W-1:0]   joy1_q;
  logic [JOY_W-1:0]   joy2_q;
  logic               done_q;
  logic               present_q;
`ifdef DB15_DEBOUNCE_EN
  logic [NBITS-1:0]   prev_q;
  logic               prev_vld_q;
`endif

  logic               present_d;
  logic [JOY_W-1:0]   joy1_d;
  logic [JOY_W-1:0]   joy2_d;
  logic               upd_d;

  // Two-flop synchronizer for the asynchronous adapter data line.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sync_q <= '0;
    else       sync_q <= {sync_q[0], joy_data};
  end

  // Frame decode; an all-low frame means no adapter, so both words are zeroed.
  always_comb begin
    present_d = (raw_q != '0);
    joy1_d    = present_d ? to_joy(raw_q[BITS_PER_PLAYER-1:0])     : '0;
    joy2_d    = present_d ? to_joy(raw_q[NBITS-1:BITS_PER_PLAYER]) : '0;
`ifdef DB15_DEBOUNCE_EN
    upd_d     = prev_vld_q && (raw_q == prev_q);
`else
    upd_d     = 1'b1;
`endif
  end

  // Reader FSM with registered adapter and joystick outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      raw_q      <= '0;
      joy_clk_q  <= 1'b1;
      joy_load_q <= 1'b1;
      joy1_q     <= '0;
      joy2_q     <= '0;
      done_q     <= 1'b0;
      present_q  <= 1'b0;
`ifdef DB15_DEBOUNCE_EN
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else if (!enable) begin
      // Abort immediately: idle lines, clear results, drop any partial frame.
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      phase_q    <= 1'b0;
      raw_q      <= '0;
      joy_clk_q  <= 1'b1;
      joy_load_q <= 1'b1;
      joy1_q     <= '0;
      joy2_q     <= '0;
      done_q     <= 1'b0;
      present_q  <= 1'b0;
`ifdef DB15_DEBOUNCE_EN
      prev_q     <= '0;
      prev_vld_q <= 1'b0;
`endif
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (tick) begin
            state_q    <= ST_LOAD;
            joy_load_q <= 1'b0;
            cnt_q      <= '0;
          end
        end
        ST_LOAD: begin
          if (tick) begin
            if (cnt_q == CNT_W'(LOAD_TICKS - 1)) begin
              state_q    <= ST_SHIFT;
              joy_load_q <= 1'b1;
              joy_clk_q  <= 1'b0;
              bit_q      <= '0;
              phase_q    <= 1'b0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!phase_q) begin
              // Sample at the end of the low half, just before the rising edge
              // that advances the adapter's shift register.
              raw_q[bit_q] <= sync_q[1];
              joy_clk_q    <= 1'b1;
              phase_q      <= 1'b1;
            end else if (bit_q == BIT_W'(NBITS - 1)) begin
              state_q <= ST_LATCH;
            end else begin
              bit_q     <= bit_q + BIT_W'(1);
              joy_clk_q <= 1'b0;
              phase_q   <= 1'b0;
            end
          end
        end
        ST_LATCH: begin
          done_q  <= 1'b1;
          state_q <= ST_GAP;
          cnt_q   <= '0;
          if (upd_d) begin
            joy1_q    <= joy1_d;
            joy2_q    <= joy2_d;
            present_q <= present_d;
          end
`ifdef DB15_DEBOUNCE_EN
          prev_q     <= raw_q;
          prev_vld_q <= 1'b1;
`endif
        end
        ST_GAP: begin
          if (tick) begin
            if (cnt_q == CNT_W'(GAP_TICKS - 1)) begin
              state_q    <= ST_LOAD;
              joy_load_q <= 1'b0;
              cnt_q      <= '0;
            end else begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign joy_clk    = joy_clk_q;
  assign joy_load   = joy_load_q;
  assign joystick1  = joy1_q;
  assign joystick2  = joy2_q;
  assign frame_done = done_q;
  assign present    = present_q;

endmodule

// File: tb/tb_db15_joy_reader.sv
// tb_db15_joy_reader: self-checking bench for db15_joy_reader with a
// behavioural adapter model and a frame_done-driven scoreboard.
// Honours DB15_DEBOUNCE_EN in its expectation model.
module tb_db15_joy_reader;

  localparam int unsigned CLK_DIV   = 24;
  localparam int unsigned GAP_TICKS = 14;

  logic        clk    = 1'b0;
  logic        reset  = 1'b1;
  logic        enable = 1'b0;
  logic        joy_data;
  logic        joy_clk;
  logic        joy_load;
  logic [15:0] joystick1;
  logic [15:0] joystick2;
  logic        frame_done;
  logic        present;

  db15_joy_reader #(.CLK_DIV(CLK_DIV), .GAP_TICKS(GAP_TICKS)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .joy_data   (joy_data),
    .joy_clk    (joy_clk),
    .joy_load   (joy_load),
    .joystick1  (joystick1),
    .joystick2  (joystick2),
    .frame_done (frame_done),
    .present    (present)
  );

  always #5 clk = ~clk;

  // Adapter: parallel load on joy_load low, shift toward bit 0 on joy_clk rise.
  logic [23:0] pat   = 24'hFFFFFF;
  logic [23:0] shreg = 24'hFFFFFF;
  always @(negedge joy_load or posedge joy_clk) begin
    if (!joy_load) shreg <= pat;
    else           shreg <= {1'b1, shreg[23:1]};
  end
  assign joy_data = shreg[0];

  typedef struct packed {
    logic [15:0] j1;
    logic [15:0] j2;
    logic        pres;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_errors++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Expected-output model; debounce holds outputs until two equal frames.
`ifdef DB15_DEBOUNCE_EN
  logic [23:0] m_prev = '0;
  logic        m_pv   = 1'b0;
  exp_t        m_out  = '0;
`endif

  task automatic push_exp(input logic [23:0] raw, input exp_t e);
`ifdef DB15_DEBOUNCE_EN
    if (m_pv && raw == m_prev) m_out = e;
    m_prev = raw;
    m_pv   = 1'b1;
    exp_q.push_back(m_out);
`else
    if (raw !== 24'hx) exp_q.push_back(e);
`endif
  endtask

  task automatic model_clear();
`ifdef DB15_DEBOUNCE_EN
    m_prev = '0;
    m_pv   = 1'b0;
    m_out  = '0;
`else
    exp_q.delete();
`endif
  endtask

  // Monitor: every frame_done pops one expectation.
  always @(negedge clk) begin
    exp_t e;
    if (frame_done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL unexpected_frame_done: got pulse expected none j1=0x%0h", joystick1);
      end else begin
        e = exp_q.pop_front();
        chk("frame_joystick1", 32'(joystick1), 32'(e.j1));
        chk("frame_joystick2", 32'(joystick2), 32'(e.j2));
        chk("frame_present",   32'(present),   32'(e.pres));
      end
    end
  end

  function automatic logic sig(input int which);
    return (which == 0) ? joy_load : joy_clk;
  endfunction

  task automatic wait_lvl(input int which, input logic val, input int budget, input string name);
    int n;
    n = 0;
    while (sig(which) !== val) begin
      @(negedge clk);
      n++;
      if (n > budget) begin
        timeout(name);
        return;
      end
    end
  endtask

  // Length of the run of `val` starting at the current sample.
  task automatic run_len(input int which, input logic val, output int n);
    n = 0;
    while (sig(which) === val && n < 5000) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0) begin
      @(negedge clk);
      n++;
      if (n > 4000) begin
        timeout(name);
        exp_q.delete();
        return;
      end
    end
  endtask

  task automatic wait_load(input string name);
    wait_lvl(0, 1'b0, 2000, name);
    wait_lvl(0, 1'b1, 200, name);
  endtask

  task automatic run_frame(input logic [23:0] raw, input exp_t e);
    pat = raw;
    push_exp(raw, e);
    wait_load("frame_load");
  endtask

  // Directed vectors: raw frame and hand-derived outputs.
  localparam int NV = 12;
  logic [23:0] v_raw [NV] = '{24'hFF7FFE, 24'h000000, 24'h000000, 24'hFFFFFF,
                              24'hFFFFEF, 24'hFFFFFF, 24'hFFFFEF, 24'hFFFFEF,
                              24'h3C35A5, 24'h3C35A5, 24'h7FFFFF, 24'h000001};
  logic [15:0] v_j1  [NV] = '{16'h0001, 16'h0000, 16'h0000, 16'h0000,
                              16'h0010, 16'h0000, 16'h0010, 16'h0010,
                              16'h0A5A, 16'h0A5A, 16'h0000, 16'h0FFE};
  logic [15:0] v_j2  [NV] = '{16'h0008, 16'h0000, 16'h0000, 16'h0000,
                              16'h0000, 16'h0000, 16'h0000, 16'h0000,
                              16'h0C3C, 16'h0C3C, 16'h0800, 16'h0FFF};
  logic        v_p   [NV] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                              1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

  function automatic exp_t vexp(input int i);
    return '{j1: v_j1[i], j2: v_j2[i], pres: v_p[i]};
  endfunction

  initial begin
    int n, total, ok_lo, ok_hi;

    repeat (3) @(negedge clk);
    chk("rst_joy_clk",    32'(joy_clk),    32'd1);
    chk("rst_joy_load",   32'(joy_load),   32'd1);
    chk("rst_joystick1",  32'(joystick1),  32'd0);
    chk("rst_joystick2",  32'(joystick2),  32'd0);
    chk("rst_frame_done", 32'(frame_done), 32'd0);
    chk("rst_present",    32'(present),    32'd0);
    reset = 1'b0;
    @(negedge clk);

    // First frame: P1 R + P2 U, with full frame timing measured.
    pat = v_raw[0];
    push_exp(v_raw[0], vexp(0));
    enable = 1'b1;
    wait_lvl(0, 1'b0, 100, "first_load");
    run_len(0, 1'b0, n);
    chk("load_low_clk", 32'(n), 32'd48);
    total = n;
    ok_lo = 0;
    ok_hi = 0;
    for (int i = 0; i < 24; i++) begin
      run_len(1, 1'b0, n);
      total += n;
      if (n == 24) ok_lo++;
      if (i < 23) begin
        run_len(1, 1'b1, n);
        total += n;
        if (n == 24) ok_hi++;
      end else begin
        run_len(0, 1'b1, n);
        total += n;
        chk("tail_high_plus_gap_clk", 32'(n), 32'd360);
      end
    end
    chk("clk_low_phases",  32'(ok_lo), 32'd24);
    chk("clk_high_phases", 32'(ok_hi), 32'd23);
    chk("frame_period",    32'(total), 32'd1536);

    // Second frame already loading with the same pattern.
    push_exp(v_raw[0], vexp(0));
    wait_lvl(0, 1'b1, 200, "second_load_end");

    for (int i = 1; i < NV; i++) run_frame(v_raw[i], vexp(i));
    wait_drain("drain_vectors");

    // Abort during bit 10 of SHIFT.
    wait_load("drop_load");
    for (int b = 0; b < 10; b++) begin
      wait_lvl(1, 1'b1, 100, "drop_bit_hi");
      wait_lvl(1, 1'b0, 100, "drop_bit_lo");
    end
    repeat (5) @(negedge clk);
    chk("pre_drop_joy_clk", 32'(joy_clk), 32'd0);
    enable = 1'b0;
    model_clear();
    @(posedge clk);
    #1;
    chk("drop_joy_clk",    32'(joy_clk),    32'd1);
    chk("drop_joy_load",   32'(joy_load),   32'd1);
    chk("drop_joystick1",  32'(joystick1),  32'd0);
    chk("drop_joystick2",  32'(joystick2),  32'd0);
    chk("drop_present",    32'(present),    32'd0);
    repeat (200) @(negedge clk);

    // Re-enable: LOAD starts on the first tick.
    pat = v_raw[0];
    push_exp(v_raw[0], vexp(0));
    enable = 1'b1;
    run_len(0, 1'b1, n);
    chk("reenable_load_delay", 32'(n), 32'd24);
    run_len(0, 1'b0, n);
    chk("reenable_load_low", 32'(n), 32'd48);
    wait_drain("drain_reenable");
    run_frame(v_raw[0], vexp(0));
    wait_drain("drain_reenable2");

    // Asynchronous reset in GAP, between clock edges.
    repeat (20) @(negedge clk);
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    chk("areset_joy_clk",    32'(joy_clk),    32'd1);
    chk("areset_joy_load",   32'(joy_load),   32'd1);
    chk("areset_joystick1",  32'(joystick1),  32'd0);
    chk("areset_joystick2",  32'(joystick2),  32'd0);
    chk("areset_frame_done", 32'(frame_done), 32'd0);
    chk("areset_present",    32'(present),    32'd0);
    model_clear();
    @(negedge clk);
    reset = 1'b0;
    run_frame(v_raw[8], vexp(8));
    run_frame(v_raw[8], vexp(8));
    wait_drain("drain_after_reset");

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
